// File: rtl/tcp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcp_pkg
// Purpose  : Shared types and constants for the TCP connection controller:
//            flag bit positions, controller state encoding and the control
//            segment request record handed to the TCP encode path.
// Revision : 1.0 - initial release
// ============================================================================
package tcp_pkg;

  // TCP flag bit positions within the 8-bit flags field
  localparam int TCP_FIN = 0;
  localparam int TCP_SYN = 1;
  localparam int TCP_RST = 2;
  localparam int TCP_PSH = 3;
  localparam int TCP_ACK = 4;

  // Flag combinations used by the control segments this block emits
  localparam logic [7:0] TCP_FLAGS_SYNACK = 8'h12;
  localparam logic [7:0] TCP_FLAGS_ACK    = 8'h10;
  localparam logic [7:0] TCP_FLAGS_FINACK = 8'h11;
  localparam logic [7:0] TCP_FLAGS_RST    = 8'h04;

  typedef enum logic [1:0] {
    ST_LISTEN      = 2'd0,
    ST_SYN_RCVD    = 2'd1,
    ST_ESTABLISHED = 2'd2,
    ST_LAST_ACK    = 2'd3
  } tcp_ctrl_state_t;

  typedef struct packed {
    logic [31:0] ip_da;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
  } tcp_ctrl_req_t;

endpackage
`default_nettype wire

// File: rtl/tcp_ctrl_tx_hold.sv
`default_nettype none
// ============================================================================
// Module   : tcp_ctrl_tx_hold
// Purpose  : Valid/ready holding register for one control segment request.
//            The request stays stable while o_valid=1 and i_ready=0. The
//            caller only loads when the slot is empty or being drained.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_ctrl_tx_hold
  import tcp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  tcp_ctrl_req_t i_req,
  input  logic          i_ready,
  output logic          o_valid,
  output tcp_ctrl_req_t o_req
);

  logic          r_valid;
  tcp_ctrl_req_t r_req;

  // Capture a new request, or retire the held one on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_req   <= i_req;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_req   = r_req;

endmodule
`default_nettype wire

// File: rtl/tcp_conn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tcp_conn_ctrl
// Purpose  : Single-connection TCP control FSM (LISTEN..LAST_ACK) for one
//            local port. Tracks sequence state and requests SYN|ACK, ACK,
//            FIN|ACK and RST control segments from the encoder.
// Options  : TCP_IDLE_TIMEOUT_EN - idle counter that resets a stale
//            connection with RST after TIMEOUT_CYCLES idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_conn_ctrl
  import tcp_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT     = 16'd80,
  parameter logic [31:0] ISN            = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd125_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic        rx_err,
  input  logic [31:0] rx_ip_sa,
  input  logic [15:0] rx_source_port,
  input  logic [15:0] rx_dest_port,
  input  logic [31:0] rx_sequence_num,
  input  logic [31:0] rx_ack_num,
  input  logic [7:0]  rx_flags,
  input  logic [15:0] rx_payload_len,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_ip_da,
  output logic [15:0] tx_source_port,
  output logic [15:0] tx_dest_port,
  output logic [31:0] tx_sequence_num,
  output logic [31:0] tx_ack_num,
  output logic [7:0]  tx_flags,
  output logic [1:0]  state,
  output logic        established
);

  tcp_ctrl_state_t r_state, w_state_nxt;
  logic [31:0] r_peer_ip, w_peer_ip_nxt;
  logic [15:0] r_peer_port, w_peer_port_nxt;
  logic [31:0] r_irs, w_irs_nxt;
  logic [31:0] r_rcv_nxt, w_rcv_nxt_nxt;
  logic [31:0] r_snd_nxt, w_snd_nxt_nxt;

  logic          w_free, w_accept, w_load, w_timeout;
  logic [31:0]   w_seg_end, w_req_seq, w_req_ack;
  logic [7:0]    w_req_flags;
  tcp_ctrl_req_t w_req, w_held;
  logic          w_syn, w_ack, w_rst, w_fin;

  assign w_syn = rx_flags[TCP_SYN];
  assign w_ack = rx_flags[TCP_ACK];
  assign w_rst = rx_flags[TCP_RST];
  assign w_fin = rx_flags[TCP_FIN];

  // A segment may only be taken when the request slot is free this cycle
  assign w_free   = !tx_valid || tx_ready;
  assign w_accept = rx_done && !rx_err && (rx_dest_port == LOCAL_PORT) && w_free &&
                    ((r_state == ST_LISTEN) ||
                     ((rx_ip_sa == r_peer_ip) && (rx_source_port == r_peer_port)));
  assign w_seg_end = r_rcv_nxt + {16'h0000, rx_payload_len} + {31'h0, w_fin};

`ifdef TCP_IDLE_TIMEOUT_EN
  logic [31:0] r_idle;
  logic        w_idle_max;
  assign w_idle_max = (r_idle == (TIMEOUT_CYCLES - 32'd1));
  // Timeout waits for a free request slot; a same-cycle segment takes priority
  assign w_timeout  = (r_state != ST_LISTEN) && w_idle_max && w_free && !w_accept;

  // Idle counter: zero in LISTEN and on any accepted segment, saturating at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if ((r_state == ST_LISTEN) || w_accept || w_timeout) begin
      r_idle <= '0;
    end else if (!w_idle_max) begin
      r_idle <= r_idle + 32'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic w_unused_flags;
  assign w_unused_flags = ^{rx_flags[7:5], rx_flags[TCP_PSH]};

  // Next-state, sequence bookkeeping and control segment request selection
  always_comb begin
    w_state_nxt     = r_state;
    w_peer_ip_nxt   = r_peer_ip;
    w_peer_port_nxt = r_peer_port;
    w_irs_nxt       = r_irs;
    w_rcv_nxt_nxt   = r_rcv_nxt;
    w_snd_nxt_nxt   = r_snd_nxt;
    w_load          = 1'b0;
    w_req_seq       = '0;
    w_req_ack       = '0;
    w_req_flags     = '0;
    if (w_accept) begin
      case (r_state)
        ST_LISTEN: begin
          if (w_syn && !w_ack && !w_rst) begin
            w_peer_ip_nxt   = rx_ip_sa;
            w_peer_port_nxt = rx_source_port;
            w_irs_nxt       = rx_sequence_num;
            w_rcv_nxt_nxt   = rx_sequence_num + 32'd1;
            w_snd_nxt_nxt   = ISN + 32'd1;
            w_load          = 1'b1;
            w_req_seq       = ISN;
            w_req_ack       = rx_sequence_num + 32'd1;
            w_req_flags     = TCP_FLAGS_SYNACK;
            w_state_nxt     = ST_SYN_RCVD;
          end
        end
        ST_SYN_RCVD: begin
          if (w_rst) begin
            w_state_nxt = ST_LISTEN;
          end else if (w_syn && (rx_sequence_num == r_irs)) begin
            w_load      = 1'b1;
            w_req_seq   = ISN;
            w_req_ack   = r_rcv_nxt;
            w_req_flags = TCP_FLAGS_SYNACK;
          end else if (w_ack && (rx_ack_num == r_snd_nxt)) begin
            w_state_nxt = ST_ESTABLISHED;
          end
        end
        ST_ESTABLISHED: begin
          if (rx_sequence_num != r_rcv_nxt) begin
            // Out-of-window data or stale RST: restate what we expect
            w_load      = 1'b1;
            w_req_seq   = r_snd_nxt;
            w_req_ack   = r_rcv_nxt;
            w_req_flags = TCP_FLAGS_ACK;
          end else if (w_rst) begin
            w_state_nxt = ST_LISTEN;
          end else begin
            w_rcv_nxt_nxt = w_seg_end;
            if (w_fin) begin
              w_load        = 1'b1;
              w_req_seq     = r_snd_nxt;
              w_req_ack     = w_seg_end;
              w_req_flags   = TCP_FLAGS_FINACK;
              w_snd_nxt_nxt = r_snd_nxt + 32'd1;
              w_state_nxt   = ST_LAST_ACK;
            end else if (rx_payload_len != 16'd0) begin
              w_load      = 1'b1;
              w_req_seq   = r_snd_nxt;
              w_req_ack   = w_seg_end;
              w_req_flags = TCP_FLAGS_ACK;
            end
          end
        end
        ST_LAST_ACK: begin
          if (w_ack && (rx_ack_num == r_snd_nxt)) begin
            w_state_nxt = ST_LISTEN;
          end else if (w_fin && (rx_sequence_num == r_rcv_nxt - 32'd1)) begin
            w_load      = 1'b1;
            w_req_seq   = r_snd_nxt - 32'd1;
            w_req_ack   = r_rcv_nxt;
            w_req_flags = TCP_FLAGS_FINACK;
          end else if (w_rst) begin
            w_state_nxt = ST_LISTEN;
          end
        end
        default: w_state_nxt = ST_LISTEN;
      endcase
    end else if (w_timeout) begin
      w_load      = 1'b1;
      w_req_seq   = r_snd_nxt;
      w_req_ack   = '0;
      w_req_flags = TCP_FLAGS_RST;
      w_state_nxt = ST_LISTEN;
    end
    w_req = '{ip_da:    w_peer_ip_nxt,
               src_port: LOCAL_PORT,
               dst_port: w_peer_port_nxt,
               seq:      w_req_seq,
               ack:      w_req_ack,
               flags:    w_req_flags};
  end

  // State and connection registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_LISTEN;
      r_peer_ip   <= '0;
      r_peer_port <= '0;
      r_irs       <= '0;
      r_rcv_nxt   <= '0;
      r_snd_nxt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_peer_ip   <= w_peer_ip_nxt;
      r_peer_port <= w_peer_port_nxt;
      r_irs       <= w_irs_nxt;
      r_rcv_nxt   <= w_rcv_nxt_nxt;
      r_snd_nxt   <= w_snd_nxt_nxt;
    end
  end

  tcp_ctrl_tx_hold u_tx_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_req   (w_req),
    .i_ready (tx_ready),
    .o_valid (tx_valid),
    .o_req   (w_held)
  );

  assign tx_ip_da        = w_held.ip_da;
  assign tx_source_port  = w_held.src_port;
  assign tx_dest_port    = w_held.dst_port;
  assign tx_sequence_num = w_held.seq;
  assign tx_ack_num      = w_held.ack;
  assign tx_flags        = w_held.flags;
  assign state           = r_state;
  assign established     = (r_state == ST_ESTABLISHED);

endmodule
`default_nettype wire

// File: tb/tb_tcp_conn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcp_conn_ctrl
// Purpose  : Self-checking bench for tcp_conn_ctrl. Expected control segments
//            are queued as stimulus is driven and compared on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcp_conn_ctrl;
  import tcp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done = 1'b0, rx_err = 1'b0;
  logic [31:0] rx_ip_sa = '0, rx_sequence_num = '0, rx_ack_num = '0;
  logic [15:0] rx_source_port = '0, rx_dest_port = '0, rx_payload_len = '0;
  logic [7:0]  rx_flags = '0;
  logic        tx_valid, tx_ready = 1'b1, established;
  logic [31:0] tx_ip_da, tx_sequence_num, tx_ack_num;
  logic [15:0] tx_source_port, tx_dest_port;
  logic [7:0]  tx_flags;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  tcp_ctrl_req_t exp_q[$];

  localparam logic [31:0] IP_A = 32'h0A00_0002;
  localparam logic [31:0] IP_B = 32'h0A00_0003;

  tcp_conn_ctrl #(
    .LOCAL_PORT(16'd80), .ISN(32'h0000_1000), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_err(rx_err), .rx_ip_sa(rx_ip_sa),
    .rx_source_port(rx_source_port), .rx_dest_port(rx_dest_port),
    .rx_sequence_num(rx_sequence_num), .rx_ack_num(rx_ack_num), .rx_flags(rx_flags),
    .rx_payload_len(rx_payload_len), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_ip_da(tx_ip_da), .tx_source_port(tx_source_port), .tx_dest_port(tx_dest_port),
    .tx_sequence_num(tx_sequence_num), .tx_ack_num(tx_ack_num), .tx_flags(tx_flags),
    .state(state), .established(established)
  );

  always #5 clk = ~clk;

  // Scoreboard: every completed handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      tcp_ctrl_req_t got, exp;
      got = '{ip_da: tx_ip_da, src_port: tx_source_port, dst_port: tx_dest_port,
              seq: tx_sequence_num, ack: tx_ack_num, flags: tx_flags};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got %h required none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL tx_segment: got %h required %h", got, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic tcp_ctrl_req_t mk(input logic [31:0] ip, input logic [15:0] dp,
                                       input logic [31:0] sq, input logic [31:0] ak,
                                       input logic [7:0] fl);
    return '{ip_da: ip, src_port: 16'd80, dst_port: dp, seq: sq, ack: ak, flags: fl};
  endfunction

  // Present one segment for one cycle; called and returns at posedge+1
  task automatic send(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                      input logic [31:0] sq, input logic [31:0] ak, input logic [7:0] fl,
                      input logic [15:0] len, input logic err);
    rx_done = 1'b1; rx_err = err; rx_ip_sa = ip; rx_source_port = sp; rx_dest_port = dp;
    rx_sequence_num = sq; rx_ack_num = ak; rx_flags = fl; rx_payload_len = len;
    @(posedge clk); #1;
    rx_done = 1'b0; rx_err = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d segments outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    n_tests++;
    if (state !== exp || established !== (exp == 2'd2)) begin
      n_fail++;
      $display("FAIL %s: state %0d est %b required state %0d", name, state, established, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (tx_valid !== 1'b0 || {tx_ip_da, tx_sequence_num, tx_ack_num, tx_flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_tx: valid %b seq %h ack %h flags %h required all 0",
               tx_valid, tx_sequence_num, tx_ack_num, tx_flags);
    end
    check_state("reset_state", 2'd0);
  endtask

  task automatic test_handshake();
    exp_q.push_back(mk(IP_A, 16'd5000, 32'h1000, 32'h101, 8'h12));
    send(IP_A, 16'd5000, 16'd80, 32'h100, 32'h0, 8'h02, 16'd0, 1'b0);
    check_state("syn_rcvd", 2'd1);
    wait_drain();
    send(IP_A, 16'd5000, 16'd80, 32'h101, 32'h1001, 8'h10, 16'd0, 1'b0);
    check_state("established", 2'd2);
  endtask

  task automatic test_data();
    exp_q.push_back(mk(IP_A, 16'd5000, 32'h1001, 32'h10B, 8'h10));
    send(IP_A, 16'd5000, 16'd80, 32'h101, 32'h1001, 8'h18, 16'd10, 1'b0);
    wait_drain();
    exp_q.push_back(mk(IP_A, 16'd5000, 32'h1001, 32'h10B, 8'h10));
    send(IP_A, 16'd5000, 16'd80, 32'h200, 32'h1001, 8'h18, 16'd5, 1'b0);
    wait_drain();
    check_state("data_state", 2'd2);
  endtask

  task automatic test_drops();
    send(IP_A, 16'd5000, 16'd80, 32'h10B, 32'h1001, 8'h11, 16'd0, 1'b1);
    check_state("drop_err", 2'd2);
    send(IP_A, 16'd5000, 16'd81, 32'h10B, 32'h1001, 8'h11, 16'd0, 1'b0);
    check_state("drop_port", 2'd2);
    send(IP_B, 16'd5000, 16'd80, 32'h10B, 32'h1001, 8'h11, 16'd0, 1'b0);
    check_state("drop_peer", 2'd2);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_close();
    exp_q.push_back(mk(IP_A, 16'd5000, 32'h1001, 32'h10C, 8'h11));
    send(IP_A, 16'd5000, 16'd80, 32'h10B, 32'h1001, 8'h11, 16'd0, 1'b0);
    check_state("last_ack", 2'd3);
    wait_drain();
    exp_q.push_back(mk(IP_A, 16'd5000, 32'h1001, 32'h10C, 8'h11));
    send(IP_A, 16'd5000, 16'd80, 32'h10B, 32'h1001, 8'h11, 16'd0, 1'b0);
    wait_drain();
    send(IP_A, 16'd5000, 16'd80, 32'h10C, 32'h1002, 8'h10, 16'd0, 1'b0);
    check_state("closed", 2'd0);
  endtask

  task automatic test_wrap_hold();
    tcp_ctrl_req_t exp;
    exp = mk(IP_B, 16'd6000, 32'h1000, 32'h0, 8'h12);
    tx_ready = 1'b0;
    exp_q.push_back(exp);
    send(IP_B, 16'd6000, 16'd80, 32'hFFFF_FFFF, 32'h0, 8'h02, 16'd0, 1'b0);
    // Would reach ESTABLISHED if accepted; slot is busy so it must drop
    send(IP_B, 16'd6000, 16'd80, 32'h0, 32'h1001, 8'h10, 16'd0, 1'b0);
    check_state("hold_drop", 2'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (tx_valid !== 1'b1 || {tx_ip_da, tx_source_port, tx_dest_port, tx_sequence_num,
                                tx_ack_num, tx_flags} !== exp) begin
        n_fail++;
        $display("FAIL hold_stable: valid %b seq %h ack %h flags %h required %h",
                 tx_valid, tx_sequence_num, tx_ack_num, tx_flags, exp);
      end
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain();
    check_state("after_hold", 2'd1);
  endtask

  task automatic test_back_to_back();
    send(IP_B, 16'd6000, 16'd80, 32'h0, 32'h1001, 8'h10, 16'd0, 1'b0);
    check_state("b2b_est", 2'd2);
    exp_q.push_back(mk(IP_B, 16'd6000, 32'h1001, 32'h4, 8'h10));
    exp_q.push_back(mk(IP_B, 16'd6000, 32'h1001, 32'h8, 8'h10));
    send(IP_B, 16'd6000, 16'd80, 32'h0, 32'h1001, 8'h18, 16'd4, 1'b0);
    send(IP_B, 16'd6000, 16'd80, 32'h4, 32'h1001, 8'h18, 16'd4, 1'b0);
    wait_drain();
    send(IP_B, 16'd6000, 16'd80, 32'h8, 32'h0, 8'h04, 16'd0, 1'b0);
    check_state("rst_listen", 2'd0);
  endtask

`ifdef TCP_IDLE_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    exp_q.push_back(mk(IP_A, 16'd7000, 32'h1000, 32'h501, 8'h12));
    send(IP_A, 16'd7000, 16'd80, 32'h500, 32'h0, 8'h02, 16'd0, 1'b0);
    wait_drain();
    exp_q.push_back(mk(IP_A, 16'd7000, 32'h1001, 32'h0, 8'h04));
    send(IP_A, 16'd7000, 16'd80, 32'h501, 32'h1001, 8'h10, 16'd0, 1'b0);
    n = 0;
    while (n < 200 && !tx_valid) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n != 101) begin
      n_fail++;
      $display("FAIL timeout_cycle: rst seen at %0d required 101", n);
    end
    wait_drain();
    check_state("timeout_listen", 2'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_handshake();
    test_data();
    test_drops();
    test_close();
    test_wrap_hold();
    test_back_to_back();
`ifdef TCP_IDLE_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tcp_conn_ctrl.md
# tcp_conn_ctrl

Single-connection TCP control state machine for one local listening port. It consumes the per-segment fields produced by the IP/TCP decode path and tracks sequence state (LISTEN through LAST_ACK). It issues control-segment requests (SYN|ACK, ACK, FIN|ACK, RST) to the TCP encode path over a valid/ready handshake. Payload bytes are not handled here; this block only sequences the connection and acknowledgements.

## Interface
Parameters:
- LOCAL_PORT, 16'd80, port this block answers on
- ISN, 32'h0000_1000, initial send sequence number
- TIMEOUT_CYCLES, 32'd125_000_000, idle limit (used only with `TCP_IDLE_TIMEOUT_EN`)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rx_done  in  1  one-cycle pulse, decoded segment fields valid
- rx_err  in  1  decode error, qualifies rx_done
- rx_ip_sa  in  32  IP source address
- rx_source_port / rx_dest_port  in  16 each
- rx_sequence_num / rx_ack_num  in  32 each
- rx_flags  in  8  TCP flags, bit0 FIN, 1 SYN, 2 RST, 3 PSH, 4 ACK
- rx_payload_len  in  16  TCP payload bytes
- tx_valid  out  1  control segment request
- tx_ready  in  1  encoder accepts
- tx_ip_da  out  32; tx_source_port / tx_dest_port  out  16; tx_sequence_num / tx_ack_num  out  32; tx_flags  out  8
- state  out  2  0 LISTEN, 1 SYN_RCVD, 2 ESTABLISHED, 3 LAST_ACK
- established  out  1  state == ESTABLISHED

## Operation
- A segment is accepted only when rx_done=1, rx_err=0, rx_dest_port==LOCAL_PORT, and no request is pending (tx_valid=0 or tx_ready=1 that cycle). Segments failing these checks are dropped with no state change.
- Outside LISTEN, the segment must also match the latched peer (ip_sa, source_port). Otherwise it is dropped.
- Internal registers: peer_ip, peer_port, irs, rcv_nxt, snd_nxt. All sequence arithmetic is modulo 2^32.
- LISTEN: on SYN=1, ACK=0, RST=0:
  - latch peer_ip/peer_port; set irs=seq, rcv_nxt=seq+1, snd_nxt=ISN+1
  - send SYN|ACK, seq=ISN, ack=seq+1; go to SYN_RCVD
  - any other segment is ignored
- SYN_RCVD:
  - RST → LISTEN
  - SYN with seq==irs → resend SYN|ACK
  - ACK with ack==snd_nxt → ESTABLISHED, no tx
  - anything else ignored
- ESTABLISHED:
  - RST with seq==rcv_nxt → LISTEN, no tx
  - seq!=rcv_nxt → duplicate ACK (seq=snd_nxt, ack=rcv_nxt); no advance
  - in-order: rcv_nxt += rx_payload_len + FIN
  - FIN set → send FIN|ACK (seq=snd_nxt, ack=new rcv_nxt); snd_nxt+=1; go to LAST_ACK
  - else payload_len>0 → send ACK; pure ACK → no tx
- LAST_ACK:
  - ACK with ack==snd_nxt → LISTEN
  - FIN with seq==rcv_nxt-1 → resend FIN|ACK (seq=snd_nxt-1)
  - RST → LISTEN
- Every tx request uses tx_ip_da=peer_ip, tx_source_port=LOCAL_PORT, tx_dest_port=peer_port.

## Timing
- Reset: state=LISTEN, all tx_* outputs 0, tx_valid=0, established=0, internal registers 0.
- Latency: tx_valid and all tx_* fields register on the edge after the accepted rx_done. State update happens on the same edge.
- While tx_valid=1 and tx_ready=0, all tx_* fields are held stable. tx_valid drops the cycle after a tx_valid && tx_ready handshake.
- If rx_done arrives in the same cycle as a handshake completing, the segment is accepted. A new request may be issued back-to-back.
- Reset asserted mid-request clears tx_valid immediately (asynchronous) and returns to LISTEN.

## Configuration
- `TCP_IDLE_TIMEOUT_EN` defined:
  - 32-bit idle counter runs in SYN_RCVD, ESTABLISHED and LAST_ACK; it clears on every accepted segment and is held at 0 in LISTEN.
  - When the counter reaches TIMEOUT_CYCLES-1: issue RST (seq=snd_nxt, ack=0, flags=RST) and go to LISTEN.
  - If a request is pending at that point, the RST is issued after its handshake.
  - If an accepted segment arrives in the same cycle as the timeout, the segment wins.
- Macro undefined: no counter; connections persist until RST or close.

## Structure
- Package tcp_pkg holds:
  - flag bit index constants (TCP_FIN..TCP_ACK)
  - state enum tcp_ctrl_state_t
  - packed struct tcp_ctrl_req_t (ip_da, ports, seq, ack, flags)
- One sub-module, tcp_ctrl_tx_hold: a valid/ready holding register for tcp_ctrl_req_t.

## Test plan
- SYN from 10.0.0.2:5000, seq=0x100 to port 80 → SYN|ACK, seq=0x1000, ack=0x101; state=1.
- Then ACK with ack=0x1001 → state=2, no tx.
- In-order segment seq=0x101, 10 bytes → ACK, seq=0x1001, ack=0x10B. Then out-of-order seq=0x200 → duplicate ACK, ack=0x10B.
- FIN at seq=0x10B → FIN|ACK, seq=0x1001, ack=0x10C. Then ACK with ack=0x1002 → LISTEN.
- SYN with seq=0xFFFF_FFFF → ack=0x0000_0000 (wrap). Hold tx_ready=0 for 5 cycles → fields stable, and a second rx_done during the hold is dropped.
- With `TCP_IDLE_TIMEOUT_EN` and TIMEOUT_CYCLES=100: after reaching ESTABLISHED with no traffic → RST at cycle 100, state=0.
